// File: rtl/port_in_conditioner.sv
// Input-port front end: two-flop synchronizer plus whole-vector debounce FSM,
// presenting a stable PortIn with sticky change flags and a change counter.
module port_in_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       RawIn,
    input  logic                   Ack,
    output logic [WIDTH-1:0]       PortIn,
    output logic                   ChangePulse,
    output logic                   Changed,
    output logic [WIDTH-1:0]       ChangedBits,
    output logic [COUNT_WIDTH-1:0] ChangeCount
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       sync1_q, sync2_q;
    logic [WIDTH-1:0]       candidate_q, candidate_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       port_in_q, port_in_d;
    logic                   change_pulse_q, change_pulse_d;
    logic                   changed_q, changed_d;
    logic [WIDTH-1:0]       changed_bits_q, changed_bits_d;
    logic [COUNT_WIDTH-1:0] change_count_q, change_count_d;
    logic                   commit;

    always_comb begin
        state_d        = state_q;
        candidate_d    = candidate_q;
        cnt_d          = cnt_q;
        port_in_d      = port_in_q;
        change_pulse_d = 1'b0;
        changed_d      = changed_q;
        changed_bits_d = changed_bits_q;
        change_count_d = change_count_q;
        commit         = 1'b0;

        case (state_q)
            ST_STABLE: begin
                if (sync2_q != port_in_q) begin
                    candidate_d = sync2_q;
                    cnt_d       = '0;
                    state_d     = ST_SETTLING;
                end
            end
            ST_SETTLING: begin
                if (sync2_q == candidate_q && cnt_q == CNT_LAST) begin
                    commit  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else if (sync2_q == candidate_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (sync2_q == port_in_q) begin
                    // Excursion returned to the accepted value: drop it silently.
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else begin
                    candidate_d = sync2_q;
                    cnt_d       = '0;
                end
            end
            default: state_d = ST_STABLE;
        endcase

        // A commit on an Ack edge wins, but only keeps the bits of this change.
        if (commit) begin
            port_in_d      = candidate_q;
            change_pulse_d = 1'b1;
            change_count_d = change_count_q + COUNT_WIDTH'(1);
            changed_d      = 1'b1;
            changed_bits_d = (Ack ? '0 : changed_bits_q) | (port_in_q ^ candidate_q);
        end else if (Ack) begin
            changed_d      = 1'b0;
            changed_bits_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            state_q        <= ST_STABLE;
            candidate_q    <= '0;
            cnt_q          <= '0;
            port_in_q      <= '0;
            change_pulse_q <= 1'b0;
            changed_q      <= 1'b0;
            changed_bits_q <= '0;
            change_count_q <= '0;
        end else begin
            sync1_q        <= RawIn;
            sync2_q        <= sync1_q;
            state_q        <= state_d;
            candidate_q    <= candidate_d;
            cnt_q          <= cnt_d;
            port_in_q      <= port_in_d;
            change_pulse_q <= change_pulse_d;
            changed_q      <= changed_d;
            changed_bits_q <= changed_bits_d;
            change_count_q <= change_count_d;
        end
    end

    assign PortIn      = port_in_q;
    assign ChangePulse = change_pulse_q;
    assign Changed     = changed_q;
    assign ChangedBits = changed_bits_q;
    assign ChangeCount = change_count_q;

endmodule
